gpr_hilo_wb: RTL and testbench

- Write-back endpoint of the pipeline: consumes the MEM/WB register outputs and commits them.
  - GPR results go into the 32x32 general register file.
  - HI/LO results go into the special HI/LO register pair.
- Serves the ID stage (GPR reads) and EX stage (HI/LO reads) with same-cycle write-through bypass, so a value written back is visible to readers in the cycle it is written.
- Keeps a free-running retire counter of committed write-backs for debug/performance.

---
 rtl/gpr_hilo_wb.sv | 103 ++++++++++
 tb/tb_gpr_hilo_wb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_hilo_wb.sv
// gpr_hilo_wb: write-back endpoint of the pipeline.
// Commits MEM/WB results into the 32x32 general register file and the HI/LO
// pair. GPR and HI/LO reads bypass the value being written in the current
// cycle. A free-running counter tracks committed write-back cycles.
module gpr_hilo_wb #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_wreg,
    input  logic [4:0]       wb_wd,
    input  logic [31:0]      wb_wdata,
    input  logic             wb_whilo,
    input  logic [31:0]      wb_hi,
    input  logic [31:0]      wb_lo,
    input  logic             re1,
    input  logic [4:0]       raddr1,
    output logic [31:0]      rdata1,
    input  logic             re2,
    input  logic [4:0]       raddr2,
    output logic [31:0]      rdata2,
    output logic [31:0]      hi_o,
    output logic [31:0]      lo_o,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [31:0] regs [NUM_REGS];
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // GPR array: writes to r0 are dropped so r0 stays architecturally zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != 5'd0)) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    // HI/LO pair is always written together, never one half alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // Retire counter: one tick per cycle with any commit, wrapping silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (wb_wreg || wb_whilo) begin
            retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Read port 1: r0 and reset read zero, then write-through bypass, then array.
    always_comb begin
        rdata1 = '0;
        if (!rst || (raddr1 == 5'd0)) begin
            rdata1 = '0;
        end else if (re1 && wb_wreg && (wb_wd == raddr1)) begin
            rdata1 = wb_wdata;
        end else if (re1) begin
            rdata1 = regs[raddr1];
        end
    end

    // Read port 2: identical priority to port 1, fully independent of it.
    always_comb begin
        rdata2 = '0;
        if (!rst || (raddr2 == 5'd0)) begin
            rdata2 = '0;
        end else if (re2 && wb_wreg && (wb_wd == raddr2)) begin
            rdata2 = wb_wdata;
        end else if (re2) begin
            rdata2 = regs[raddr2];
        end
    end

    // HI/LO read: the pair being written this cycle is forwarded to EX.
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (wb_whilo) begin
            hi_o = wb_hi;
            lo_o = wb_lo;
        end else begin
            hi_o = hi_q;
            lo_o = lo_q;
        end
    end

endmodule

// File: tb/tb_gpr_hilo_wb.sv
// tb_gpr_hilo_wb: scoreboard bench for gpr_hilo_wb.
// Stimulus drives one cycle at a time and pushes the expected outputs;
// an independent monitor pops and compares at every falling edge.
// A second instance with a 4-bit counter exercises the wrap from 15 to 0.
module tb_gpr_hilo_wb;

    logic        clk;
    logic        rst;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;

    logic [31:0] rdata1, rdata2, hi_o, lo_o, retire_cnt;
    logic [31:0] rdata1_s, rdata2_s, hi_s, lo_s;
    logic [3:0]  retire_cnt_s;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cnt;
    } expect_t;

    expect_t expQ[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: architectural view of the block.
    logic [31:0] mRegs [32];
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic [31:0] mCnt;

    gpr_hilo_wb #(.NUM_REGS(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .retire_cnt(retire_cnt)
    );

    gpr_hilo_wb #(.NUM_REGS(32), .CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1_s),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2_s),
        .hi_o(hi_s), .lo_o(lo_s), .retire_cnt(retire_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clear the model exactly as an asserted reset clears the block.
    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        mHi  = '0;
        mLo  = '0;
        mCnt = '0;
    endtask

    // Apply the architectural effect of a rising edge with the current inputs.
    task automatic modelCommit();
        if (rst) begin
            if (wb_wreg && wb_wd != 5'd0) mRegs[wb_wd] = wb_wdata;
            if (wb_whilo) begin
                mHi = wb_hi;
                mLo = wb_lo;
            end
            if (wb_wreg || wb_whilo) mCnt = mCnt + 32'd1;
        end
    endtask

    function automatic logic [31:0] modelRead(input logic re, input logic [4:0] a);
        if (!rst)                             return 32'd0;
        if (a == 5'd0)                        return 32'd0;
        if (re && wb_wreg && wb_wd == a)      return wb_wdata;
        if (re)                               return mRegs[a];
        return 32'd0;
    endfunction

    task automatic pushExpected();
        expect_t e;
        e.r1  = modelRead(re1, raddr1);
        e.r2  = modelRead(re2, raddr2);
        e.hi  = !rst ? 32'd0 : (wb_whilo ? wb_hi : mHi);
        e.lo  = !rst ? 32'd0 : (wb_whilo ? wb_lo : mLo);
        e.cnt = mCnt;
        expQ.push_back(e);
    endtask

    // One cycle: commit the previous inputs at the edge, then drive new ones.
    task automatic applyStimulus(input logic rstIn,
                                 input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                                 input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                                 input logic r1e, input logic [4:0] a1,
                                 input logic r2e, input logic [4:0] a2);
        @(posedge clk);
        modelCommit();
        #1;
        rst      = rstIn;
        wb_wreg  = wreg;
        wb_wd    = wd;
        wb_wdata = wdata;
        wb_whilo = whilo;
        wb_hi    = hi;
        wb_lo    = lo;
        re1      = r1e;
        raddr1   = a1;
        re2      = r2e;
        raddr2   = a2;
        if (!rst) modelReset();
        pushExpected();
    endtask

    // Assert reset between edges while a write is pending in the same cycle.
    task automatic resetMidCycle();
        @(posedge clk);
        modelCommit();
        #1;
        wb_wreg  = 1'b1;
        wb_wd    = 5'd5;
        wb_wdata = 32'h5555_5555;
        wb_whilo = 1'b1;
        wb_hi    = 32'h7777_7777;
        wb_lo    = 32'h8888_8888;
        re1      = 1'b1;
        raddr1   = 5'd5;
        re2      = 1'b1;
        raddr2   = 5'd7;
        #2;
        rst = 1'b0;
        modelReset();
        pushExpected();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("rdata1", rdata1, e.r1);
                checkOutput("rdata2", rdata2, e.r2);
                checkOutput("hi_o", hi_o, e.hi);
                checkOutput("lo_o", lo_o, e.lo);
                checkOutput("retire_cnt", retire_cnt, e.cnt);
                checkOutput("small_rdata1", rdata1_s, e.r1);
                checkOutput("small_rdata2", rdata2_s, e.r2);
                checkOutput("small_hi_o", hi_s, e.hi);
                checkOutput("small_lo_o", lo_s, e.lo);
                checkOutput("small_retire_cnt", {28'd0, retire_cnt_s}, {28'd0, e.cnt[3:0]});
            end
        end
    end

    initial begin
        int drain;
        logic        rr;
        logic [4:0]  wd, a1, a2;

        rst = 1'b0; wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
        wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        modelReset();

        // Directed cases
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd1, 1, 5'd2);
        applyStimulus(1, 1, 5'd7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 1, 5'd7);
        applyStimulus(1, 1, 5'd3, 32'h0000_0011, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 5'd3, 32'h0000_00FF, 0, 0, 0, 1, 5'd3, 0, 5'd3);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd3, 1, 5'd3);
        applyStimulus(1, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'd0, 1, 5'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0);
        applyStimulus(1, 1, 5'd9, 32'h0000_0099, 1, 32'h1, 32'h2, 1, 5'd9, 1, 5'd9);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
        applyStimulus(1, 1, 5'd5, 32'h1234_5678, 1, 32'hAAAA_0000, 32'h0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 1, 5'd7);
        resetMidCycle();
        applyStimulus(0, 1, 5'd6, 32'h6666_6666, 1, 32'h3, 32'h4, 1, 5'd6, 1, 5'd5);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 1, 5'd6);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 1, 5'd9);

        // Randomized traffic, addresses biased low so bypass hits are common
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 60) != 0);
            wd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            applyStimulus(rr, 1'($urandom), wd, $urandom,
                          ($urandom_range(0, 3) == 0), $urandom, $urandom,
                          1'($urandom), a1, 1'($urandom), a2);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
